// File: rtl/picocpu_mem_if.sv
// picocpu_mem_if: bus between the picoCPU core/program loader and the
// memory stage.
//   addr/re/we/wdata : core bus request (6-bit address, 8-bit data)
//   rdata            : registered read data back to the core
//   ld_start         : pulse that begins a new load session
//   ld_valid/ld_data/ld_last : loader byte stream
//   ld_ready         : memory stage can take a loader byte this cycle
// master = core + loader side, slave = memory stage.
interface picocpu_mem_if;
  logic [5:0] addr;
  logic       re;
  logic       we;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       ld_start;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_last;
  logic       ld_ready;

  modport master (
    output addr, re, we, wdata, ld_start, ld_valid, ld_data, ld_last,
    input  rdata, ld_ready
  );

  modport slave (
    input  addr, re, we, wdata, ld_start, ld_valid, ld_data, ld_last,
    output rdata, ld_ready
  );
endinterface

// File: rtl/picocpu_mem.sv
// picocpu_mem: memory and load-control stage for the picoCPU core.
// 64x8 synchronous RAM with one-cycle registered reads, one memory-mapped
// output port at IO_ADDR, and a byte-stream loader that keeps the core in
// reset while RAM is filled, then releases it HOLD_CYC cycles later.
// Ports:
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   bus      : core bus + loader stream (picocpu_mem_if.slave)
//   cpu_res  : active-high reset to the core (registered)
//   port_out : output port register
module picocpu_mem #(
  parameter logic [5:0] IO_ADDR  = 6'h3F,
  parameter int         HOLD_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  picocpu_mem_if.slave      bus,
  output logic              cpu_res,
  output logic [7:0]        port_out
);

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_RELEASE,
    ST_RUN
  } state_t;

  state_t      state;
  logic [5:0]  ptr;
  logic [3:0]  hold_cnt;
  logic [7:0]  rdata_q;
  logic        ld_ready_q;
  logic [7:0]  mem [64];

  logic        load_xfer;
  logic        run_ok;
  logic        io_hit;
  logic        core_wr;

  // A new session request masks the loader handshake in the same cycle,
  // so a byte offered alongside ld_start is never accepted.
  assign bus.ld_ready = ld_ready_q & ~bus.ld_start;
  assign bus.rdata    = rdata_q;

  assign load_xfer = (state == ST_LOAD) && bus.ld_valid && bus.ld_ready;
  assign run_ok    = (state == ST_RUN) && !bus.ld_start;
  assign io_hit    = (bus.addr == IO_ADDR);
  assign core_wr   = run_ok && bus.we && !io_hit;

  // RAM array has no reset so contents survive rst_n and reloads.
  always_ff @(posedge clk) begin
    if (load_xfer) begin
      mem[ptr] <= bus.ld_data;
    end else if (core_wr) begin
      mem[bus.addr] <= bus.wdata;
    end
  end

  // Control FSM; reads sample the pre-edge RAM value, which gives
  // read-before-write when RE and WE hit the same address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_LOAD;
      ptr        <= 6'd0;
      hold_cnt   <= 4'd0;
      rdata_q    <= 8'h00;
      port_out   <= 8'h00;
      cpu_res    <= 1'b1;
      ld_ready_q <= 1'b1;
    end else if (bus.ld_start) begin
      if (state == ST_RUN) begin
        port_out <= 8'h00;
      end
      state      <= ST_LOAD;
      ptr        <= 6'd0;
      hold_cnt   <= 4'd0;
      cpu_res    <= 1'b1;
      ld_ready_q <= 1'b1;
    end else begin
      case (state)
        ST_LOAD: begin
          if (load_xfer) begin
            if (bus.ld_last || ptr == 6'd63) begin
              state      <= ST_RELEASE;
              ptr        <= 6'd0;
              hold_cnt   <= 4'd0;
              ld_ready_q <= 1'b0;
            end else begin
              ptr <= ptr + 6'd1;
            end
          end
        end
        ST_RELEASE: begin
          if (hold_cnt == 4'(HOLD_CYC - 1)) begin
            state   <= ST_RUN;
            cpu_res <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 4'd1;
          end
        end
        ST_RUN: begin
          if (bus.re) begin
            rdata_q <= io_hit ? port_out : mem[bus.addr];
          end
          if (bus.we && io_hit) begin
            port_out <= bus.wdata;
          end
        end
        default: begin
          state <= ST_LOAD;
        end
      endcase
    end
  end

endmodule
